card_column_sequencer: RTL and testbench
========================================

Name: card_column_sequencer

Overview:
Sequences card-column decoding for the card reader path. It accepts one 12-row punch column at a time and runs it through one shared 12-bit priority-decode unit in two passes: a zone pass, then a digit pass. It assembles the zone, digit and error result for each column and presents it downstream. It counts columns per card and flags the last one.

Parameters:
NCOLS, 80, columns per card.
COLW, 7, width of the column counter; must satisfy 2^COLW >= NCOLS.

Ports:
i_clk  in  1  clock.
i_rst  in  1  reset; asynchronous, active-high.
i_start  in  1  begin a card; honoured only in IDLE.
i_col  in  12  punch column. Bit 11 = row 12, bit 10 = row 11, bit 9 = row 0, bits 8..0 = rows 1..9 (bit 8 = row 1, bit 0 = row 9).
i_col_valid  in  1  column available.
o_col_ready  out  1  sequencer accepts a column.
o_zone  out  2  0 = none, 1 = row 12, 2 = row 11, 3 = row 0 used as zone.
o_digit  out  4  0..9, or 15 = no digit.
o_multi  out  1  more than one punch in the zone group or in the digit group.
o_blank  out  1  column had no punches.
o_colnum  out  COLW  index of the presented column, 0-based.
o_eoc  out  1  presented column is column NCOLS-1.
o_valid  out  1  result valid.
i_ready  in  1  downstream accepts the result.
o_busy  out  1  state != IDLE.

Behaviour:
- Shared decode unit:
  - Input is a 12-bit masked vector.
  - Index = (position of highest set bit) + 1, or 0 if no bit is set.
  - count_gt1 = more than one bit set.
- FSM states: IDLE, WAIT, ZONE, DIGIT, OUT.
- IDLE:
  - o_col_ready = 0.
  - On i_start: column counter cleared to 0, go to WAIT.
- WAIT:
  - o_col_ready = 1.
  - On i_col_valid: capture i_col into a holding register, go to ZONE.
- ZONE:
  - Decode unit input = cap & 12'hE00.
  - Index 12 -> zone 1; 11 -> zone 2; 10 -> zone 3; 0 -> zone 0.
  - Latch the zone code and the zone count_gt1.
  - Go to DIGIT.
- DIGIT:
  - Decode unit input = cap & 12'h1FF.
  - Index k (1..9) -> digit = 10 - k. Index 0 -> digit 15.
  - Latch the digit and the digit count_gt1.
  - Go to OUT.
- Row 0 rule: if zone = 3, the zone group holds only row 0, and digit = 15, the column is the digit 0. Present zone 0, digit 0.
- o_multi = zone count_gt1 OR digit count_gt1. Example: 11+0 (12'h600) gives multi = 1 and zone = 2, since the highest zone row wins.
- o_blank = (cap == 0). A blank column presents zone 0, digit 15.
- OUT:
  - o_valid = 1. All result outputs are stable while o_valid is high and i_ready is low.
  - On i_ready: if the counter == NCOLS-1, go to IDLE; otherwise increment the counter and go to WAIT.
- o_eoc = o_valid AND (counter == NCOLS-1).
- Latency and throughput:
  - Accept handshake at cycle N; o_valid is high from cycle N+3.
  - Minimum 4 cycles per column.
  - No column is accepted while a result is pending.
- i_start outside IDLE is ignored.
- Reset:
  - Assertion at any time returns to IDLE and discards any in-flight column.
  - Output reset values: o_valid 0, o_col_ready 0, o_busy 0, o_eoc 0, o_zone 0, o_digit 15, o_multi 0, o_blank 0, o_colnum 0.
- The counter never wraps within a card. The terminal transition to IDLE is at NCOLS-1.

Test Plan:
- Reset, then i_start, then column 12'h000 with i_ready=1 -> o_valid 3 cycles after accept; zone 0, digit 15, blank 1, multi 0, colnum 0.
- Columns 12'h010, 12'h200, 12'h900 -> results in order:
  - 12'h010 (row 5): zone 0, digit 5.
  - 12'h200 (row 0): zone 0, digit 0.
  - 12'h900 (12-1, "A"): zone 1, digit 1, multi 0.
  - colnum 1, 2, 3 respectively.
- Multi-punch:
  - 12'h600 -> zone 2, multi 1.
  - 12'h030 (rows 4,5) -> digit 4, multi 1.
  - 12'h0FF -> multi 1.
- Backpressure: hold i_ready=0 for 10 cycles in OUT -> outputs stable; o_col_ready 0; a column offered on i_col is not taken until after the release.
- Full card of NCOLS columns -> o_eoc high only with colnum 79; then IDLE, o_busy 0, o_col_ready 0; a further i_col_valid is not accepted until i_start.
- Assert i_rst while in DIGIT -> o_valid never rises for that column; all outputs at reset values; a new i_start restarts at colnum 0.

Source files
------------

// File: rtl/card_column_sequencer.sv
// card_column_sequencer
//   Decodes one 12-row punch column at a time through a single shared
//   priority-decode unit, first over the zone rows (12, 11, 0) and then over
//   the digit rows (1..9). The assembled zone/digit/multi/blank result is held
//   on the outputs until downstream takes it. Columns are counted per card and
//   the last column of the card is flagged.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start             begin a card (only honoured while idle)
//   i_col, i_col_valid  punch column offer; o_col_ready accepts it
//   o_zone, o_digit     decoded zone code and digit (15 = no digit)
//   o_multi, o_blank    multi-punch in a group / column without punches
//   o_colnum, o_eoc     0-based column index / last column of the card
//   o_valid, i_ready    result handshake
//   o_busy              sequencer is not idle
module card_column_sequencer #(
  parameter int NCOLS = 80,
  parameter int COLW  = 7
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [11:0]     i_col,
  input  logic            i_col_valid,
  output logic            o_col_ready,
  output logic [1:0]      o_zone,
  output logic [3:0]      o_digit,
  output logic            o_multi,
  output logic            o_blank,
  output logic [COLW-1:0] o_colnum,
  output logic            o_eoc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_busy
);

  localparam logic [COLW-1:0] LAST_COL = COLW'(NCOLS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ZONE  = 3'd2,
    S_DIGIT = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  // Position of the highest set bit plus one; zero when nothing is set.
  function automatic logic [3:0] prio_index(input logic [11:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (v[i]) begin
        idx = 4'(i + 1);
      end
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic more_than_one(input logic [11:0] v);
    return (v & (v - 12'd1)) != 12'd0;
  endfunction

  state_t          state_r, state_s;
  logic [11:0]     cap_r;
  logic [1:0]      zone_code_r;
  logic            zone_multi_r;
  logic [COLW-1:0] cnt_r;
  logic [1:0]      zone_out_r;
  logic [3:0]      digit_out_r;
  logic            multi_out_r, blank_out_r;
  logic            valid_r, col_ready_r, busy_r, eoc_r;

  logic [11:0]     dec_in_s;
  logic [3:0]      dec_idx_s;
  logic            dec_gt1_s;
  logic [1:0]      zone_map_s;
  logic [3:0]      digit_map_s;
  logic [1:0]      fin_zone_s;
  logic [3:0]      fin_digit_s;

  // Shared decode unit: the masked group depends on which pass is running.
  always_comb begin
    dec_in_s = 12'h000;
    case (state_r)
      S_ZONE:  dec_in_s = cap_r & 12'hE00;
      S_DIGIT: dec_in_s = cap_r & 12'h1FF;
      default: dec_in_s = 12'h000;
    endcase
    dec_idx_s = prio_index(dec_in_s);
    dec_gt1_s = more_than_one(dec_in_s);
  end

  // Map decode index to zone code and digit; apply the lone-row-0 rule.
  always_comb begin
    case (dec_idx_s)
      4'd12:   zone_map_s = 2'd1;
      4'd11:   zone_map_s = 2'd2;
      4'd10:   zone_map_s = 2'd3;
      default: zone_map_s = 2'd0;
    endcase
    if (dec_idx_s == 4'd0) begin
      digit_map_s = 4'd15;
    end else begin
      digit_map_s = 4'd10 - dec_idx_s;
    end
    // Row 0 punched alone (no digit row) is the digit 0, not a zone.
    if (zone_code_r == 2'd3 && !zone_multi_r && digit_map_s == 4'd15) begin
      fin_zone_s  = 2'd0;
      fin_digit_s = 4'd0;
    end else begin
      fin_zone_s  = zone_code_r;
      fin_digit_s = digit_map_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (i_start) state_s = S_WAIT;
        else         state_s = S_IDLE;
      end
      S_WAIT: begin
        if (i_col_valid) state_s = S_ZONE;
        else             state_s = S_WAIT;
      end
      S_ZONE:  state_s = S_DIGIT;
      S_DIGIT: state_s = S_OUT;
      S_OUT: begin
        if (!i_ready)               state_s = S_OUT;
        else if (cnt_r == LAST_COL) state_s = S_IDLE;
        else                        state_s = S_WAIT;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, capture, counter and pass results.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= S_IDLE;
      cap_r        <= 12'h000;
      zone_code_r  <= 2'd0;
      zone_multi_r <= 1'b0;
      cnt_r        <= '0;
      zone_out_r   <= 2'd0;
      digit_out_r  <= 4'd15;
      multi_out_r  <= 1'b0;
      blank_out_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == S_IDLE && i_start) begin
        cnt_r <= '0;
      end else if (state_r == S_OUT && i_ready && cnt_r != LAST_COL) begin
        cnt_r <= cnt_r + COLW'(1);
      end
      if (state_r == S_WAIT && i_col_valid) begin
        cap_r <= i_col;
      end
      if (state_r == S_ZONE) begin
        zone_code_r  <= zone_map_s;
        zone_multi_r <= dec_gt1_s;
      end
      // Result registers only change on entry to OUT, so they stay stable
      // for as long as downstream stalls.
      if (state_r == S_DIGIT) begin
        zone_out_r  <= fin_zone_s;
        digit_out_r <= fin_digit_s;
        multi_out_r <= zone_multi_r | dec_gt1_s;
        blank_out_r <= (cap_r == 12'h000);
      end
    end
  end

  // Handshake/status flags registered from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_r     <= 1'b0;
      col_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      eoc_r       <= 1'b0;
    end else begin
      valid_r     <= (state_s == S_OUT);
      col_ready_r <= (state_s == S_WAIT);
      busy_r      <= (state_s != S_IDLE);
      eoc_r       <= (state_s == S_OUT) && (cnt_r == LAST_COL);
    end
  end

  assign o_col_ready = col_ready_r;
  assign o_zone      = zone_out_r;
  assign o_digit     = digit_out_r;
  assign o_multi     = multi_out_r;
  assign o_blank     = blank_out_r;
  assign o_colnum    = cnt_r;
  assign o_eoc       = eoc_r;
  assign o_valid     = valid_r;
  assign o_busy      = busy_r;

endmodule

// File: tb/tb_card_column_sequencer.sv
// Testbench for card_column_sequencer: directed columns, a cycle-level
// reference model of the column protocol, and a per-cycle compare process.
module tb_card_column_sequencer;
  localparam int NCOLS = 80;
  localparam int COLW  = 7;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_start = 1'b0;
  logic [11:0]     i_col = 12'h000;
  logic            i_col_valid = 1'b0;
  logic            i_ready = 1'b0;
  logic            o_col_ready;
  logic [1:0]      o_zone;
  logic [3:0]      o_digit;
  logic            o_multi;
  logic            o_blank;
  logic [COLW-1:0] o_colnum;
  logic            o_eoc;
  logic            o_valid;
  logic            o_busy;

  card_column_sequencer #(.NCOLS(NCOLS), .COLW(COLW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_col(i_col),
    .i_col_valid(i_col_valid), .o_col_ready(o_col_ready), .o_zone(o_zone),
    .o_digit(o_digit), .o_multi(o_multi), .o_blank(o_blank),
    .o_colnum(o_colnum), .o_eoc(o_eoc), .o_valid(o_valid),
    .i_ready(i_ready), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference decode from the punch-card rules: {zone, digit, multi, blank}.
  function automatic logic [7:0] ref_decode(input logic [11:0] c);
    logic [1:0] z;
    logic [3:0] d;
    logic m;
    if (c[11])      z = 2'd1;
    else if (c[10]) z = 2'd2;
    else if (c[9])  z = 2'd3;
    else            z = 2'd0;
    d = 4'd15;
    for (int r = 9; r >= 1; r--) begin
      if (c[9 - r]) d = 4'(r);
    end
    m = ($countones(c[11:9]) > 1) || ($countones(c[8:0]) > 1);
    if (c[11:9] == 3'b001 && c[8:0] == 9'd0) begin
      z = 2'd0;
      d = 4'd0;
    end
    return {z, d, m, (c == 12'h000)};
  endfunction

  // Protocol model: card active, waiting for a column, cycles since accept.
  bit         m_active = 1'b0;
  bit         m_wait = 1'b0;
  int         m_age = 0;
  int         m_cnt = 0;
  logic [7:0] m_res = 8'h3C;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_active = 1'b0;
      m_wait   = 1'b0;
      m_age    = 0;
      m_cnt    = 0;
    end else if (!m_active) begin
      if (i_start) begin
        m_active = 1'b1;
        m_wait   = 1'b1;
        m_cnt    = 0;
      end
    end else if (m_wait) begin
      if (i_col_valid) begin
        m_wait = 1'b0;
        m_age  = 1;
        m_res  = ref_decode(i_col);
      end
    end else if (m_age < 3) begin
      m_age++;
    end else if (i_ready) begin
      if (m_cnt == NCOLS - 1) begin
        m_active = 1'b0;
      end else begin
        m_cnt++;
        m_wait = 1'b1;
      end
    end
  end

  logic        e_valid;
  logic [10:0] e_ctl, a_ctl;
  logic [7:0]  a_res;

  // Compare process: control outputs every cycle, result whenever valid.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      e_valid = m_active && !m_wait && (m_age == 3);
      e_ctl = {m_active, m_active && m_wait, e_valid,
               e_valid && (m_cnt == NCOLS - 1), 7'(m_cnt)};
      a_ctl = {o_busy, o_col_ready, o_valid, o_eoc, o_colnum};
      checks++;
      if (a_ctl !== e_ctl) begin
        errors++;
        $display("FAIL ctl t=%0t got busy/rdy/vld/eoc/col=%b expected %b",
                 $time, a_ctl, e_ctl);
      end
      if (e_valid) begin
        a_res = {o_zone, o_digit, o_multi, o_blank};
        checks++;
        if (a_res !== m_res) begin
          errors++;
          $display("FAIL result t=%0t got zone/digit/multi/blank=%h expected %h",
                   $time, a_res, m_res);
        end
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int         r_lat;
  logic [1:0] r_zone;
  logic [3:0] r_digit;
  logic       r_multi, r_blank, r_eoc;
  int         r_col;

  // Offer a column, wait for its result, optionally stall, then take it.
  task automatic send_col(input logic [11:0] col, input int hold, input bit offer);
    int t;
    i_col = col;
    i_col_valid = 1'b1;
    t = 0;
    while (!o_col_ready && t < 40) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_col_ready) begin
      check_lit("accept_timeout", 0, 1);
      i_col_valid = 1'b0;
      return;
    end
    @(negedge i_clk);
    i_col_valid = 1'b0;
    t = 1;
    while (!o_valid && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_valid) check_lit("valid_timeout", 0, 1);
    r_lat = t;
    r_zone = o_zone;
    r_digit = o_digit;
    r_multi = o_multi;
    r_blank = o_blank;
    r_eoc = o_eoc;
    r_col = int'(o_colnum);
    for (int h = 0; h < hold; h++) begin
      if (offer) begin
        i_col = 12'h081;
        i_col_valid = 1'b1;
      end
      @(negedge i_clk);
      check_lit("stall_no_ready", int'(o_col_ready), 0);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_lit({tag, "_valid"}, int'(o_valid), 0);
    check_lit({tag, "_ready"}, int'(o_col_ready), 0);
    check_lit({tag, "_busy"}, int'(o_busy), 0);
    check_lit({tag, "_eoc"}, int'(o_eoc), 0);
    check_lit({tag, "_zone"}, int'(o_zone), 0);
    check_lit({tag, "_digit"}, int'(o_digit), 15);
    check_lit({tag, "_multi"}, int'(o_multi), 0);
    check_lit({tag, "_blank"}, int'(o_blank), 0);
    check_lit({tag, "_colnum"}, int'(o_colnum), 0);
  endtask

  initial begin
    // Pin the reference decode with hand-computed values.
    check_lit("pin_000", int'(ref_decode(12'h000)), 8'h3D);
    check_lit("pin_900", int'(ref_decode(12'h900)), 8'h44);
    check_lit("pin_200", int'(ref_decode(12'h200)), 8'h00);
    check_lit("pin_600", int'(ref_decode(12'h600)), 8'hBE);

    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check_reset_outputs("rst");

    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;

    send_col(12'h000, 0, 1'b0);
    check_lit("blank_latency", r_lat, 3);
    check_lit("blank_zone", int'(r_zone), 0);
    check_lit("blank_digit", int'(r_digit), 15);
    check_lit("blank_blank", int'(r_blank), 1);
    check_lit("blank_multi", int'(r_multi), 0);
    check_lit("blank_col", r_col, 0);

    send_col(12'h010, 0, 1'b0);
    check_lit("row5_zone", int'(r_zone), 0);
    check_lit("row5_digit", int'(r_digit), 5);
    check_lit("row5_col", r_col, 1);

    send_col(12'h200, 1, 1'b0);
    check_lit("row0_zone", int'(r_zone), 0);
    check_lit("row0_digit", int'(r_digit), 0);
    check_lit("row0_col", r_col, 2);

    send_col(12'h900, 0, 1'b0);
    check_lit("a_zone", int'(r_zone), 1);
    check_lit("a_digit", int'(r_digit), 1);
    check_lit("a_multi", int'(r_multi), 0);
    check_lit("a_col", r_col, 3);

    send_col(12'h600, 0, 1'b0);
    check_lit("z11_0_zone", int'(r_zone), 2);
    check_lit("z11_0_multi", int'(r_multi), 1);

    send_col(12'h030, 0, 1'b0);
    check_lit("r45_digit", int'(r_digit), 4);
    check_lit("r45_multi", int'(r_multi), 1);

    send_col(12'h0FF, 0, 1'b0);
    check_lit("r2to9_multi", int'(r_multi), 1);

    // Stall 10 cycles while another column is already offered.
    send_col(12'h008, 10, 1'b1);
    check_lit("stall_digit", int'(r_digit), 6);
    check_lit("stall_col", r_col, 7);
    send_col(12'h081, 0, 1'b0);
    check_lit("after_stall_digit", int'(r_digit), 2);
    check_lit("after_stall_col", r_col, 8);

    for (int i = 9; i < NCOLS; i++) begin
      send_col(12'((i * 293) & 12'hFFF), i % 3, 1'b0);
      if (i == NCOLS - 2) check_lit("eoc_col78", int'(r_eoc), 0);
      if (i == NCOLS - 1) begin
        check_lit("eoc_col79", int'(r_eoc), 1);
        check_lit("eoc_colnum", r_col, 79);
      end
    end

    @(negedge i_clk);
    check_lit("card_end_busy", int'(o_busy), 0);
    check_lit("card_end_ready", int'(o_col_ready), 0);
    i_col = 12'h100;
    i_col_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check_lit("idle_no_accept", int'(o_col_ready), 0);
    end
    check_lit("idle_busy", int'(o_busy), 0);
    i_col_valid = 1'b0;

    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    send_col(12'h201, 0, 1'b0);
    check_lit("card2_col", r_col, 0);
    check_lit("card2_zone", int'(r_zone), 3);
    check_lit("card2_digit", int'(r_digit), 9);

    // Reset while the next column is in its digit pass.
    i_col = 12'h480;
    i_col_valid = 1'b1;
    @(negedge i_clk);
    i_col_valid = 1'b0;
    @(negedge i_clk);
    check_lit("digit_busy", int'(o_busy), 1);
    check_lit("digit_valid", int'(o_valid), 0);
    #2 i_rst = 1'b1;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check_lit("post_rst_valid", int'(o_valid), 0);
    end

    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    send_col(12'h400, 0, 1'b0);
    check_lit("restart_col", r_col, 0);
    check_lit("restart_zone", int'(r_zone), 2);
    check_lit("restart_digit", int'(r_digit), 15);
    check_lit("restart_blank", int'(r_blank), 0);

    repeat (2) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
